// File: rtl/core_switch_ctrl.sv
// core_switch_ctrl: ownership arbiter for two redundant cores (A/B) sharing one UART/IO path.
// Tracks heartbeat health, drives the mux select, enforces a post-switch holdoff,
// accepts forced switches, counts switchovers and reports the both-failed condition.
// Optional build macro: CORE_SWITCH_REVERT_EN (auto-revert to core A after a healthy period).
module core_switch_ctrl #(
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned REVERT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hb_ok_a,
    input  logic       hb_ok_b,
    input  logic       force_req,
    input  logic       force_sel,
    output logic       sel,
    output logic       switch_pulse,
    output logic       both_fail,
    output logic       holdoff,
    output logic [7:0] switch_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ACT_A, S_ACT_B, S_FAIL} state_t;

    localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          pulse_q, pulse_d;
    logic          hold_q, hold_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          do_switch;

`ifdef CORE_SWITCH_REVERT_EN
    localparam int unsigned RW = (REVERT_CYCLES > 1) ? $clog2(REVERT_CYCLES) : 1;
    localparam logic [RW-1:0] REV_LAST = RW'(REVERT_CYCLES - 1);
    logic [RW-1:0] rev_cnt_q, rev_cnt_d;
`endif

    // Next-state, switch decision, holdoff countdown and optional revert timer
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pulse_d    = 1'b0;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        do_switch  = 1'b0;
`ifdef CORE_SWITCH_REVERT_EN
        rev_cnt_d  = '0;
`endif

        if (hold_q) begin
            if (hold_cnt_q == '0) hold_d = 1'b0;
            else                  hold_cnt_d = hold_cnt_q - 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (hb_ok_a) begin
                    state_d = S_ACT_A;
                end else if (hb_ok_b) begin
                    state_d   = S_ACT_B;
                    do_switch = 1'b1;
                end
            end
            S_ACT_A: begin
                if (!hb_ok_a) begin
                    if (hb_ok_b && !hold_q) begin
                        state_d   = S_ACT_B;
                        do_switch = 1'b1;
                    end else if (!hb_ok_b) begin
                        state_d = S_FAIL;
                    end
                end else if (force_req && force_sel && hb_ok_b && !hold_q) begin
                    state_d   = S_ACT_B;
                    do_switch = 1'b1;
                end
            end
            S_ACT_B: begin
                if (!hb_ok_b) begin
                    if (hb_ok_a && !hold_q) begin
                        state_d   = S_ACT_A;
                        do_switch = 1'b1;
                    end else if (!hb_ok_a) begin
                        state_d = S_FAIL;
                    end
                end else if (force_req && !force_sel && hb_ok_a && !hold_q) begin
                    state_d   = S_ACT_A;
                    do_switch = 1'b1;
                end
`ifdef CORE_SWITCH_REVERT_EN
                else if (!hold_q && hb_ok_a && !(force_req && force_sel)) begin
                    if (rev_cnt_q == REV_LAST) begin
                        state_d   = S_ACT_A;
                        do_switch = 1'b1;
                    end else begin
                        rev_cnt_d = rev_cnt_q + 1'b1;
                    end
                end
`endif
            end
            S_FAIL: begin
                if (hb_ok_a && hb_ok_b) begin
                    state_d = sel_q ? S_ACT_B : S_ACT_A;
                end else if (hb_ok_a) begin
                    state_d   = S_ACT_A;
                    do_switch = sel_q;
                end else if (hb_ok_b) begin
                    state_d   = S_ACT_B;
                    do_switch = !sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_switch) begin
            sel_d      = !sel_q;
            pulse_d    = 1'b1;
            hold_d     = 1'b1;
            hold_cnt_d = HOLD_LOAD;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            pulse_q    <= 1'b0;
            hold_q     <= 1'b0;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pulse_q    <= pulse_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef CORE_SWITCH_REVERT_EN
    // Revert timer register
    always_ff @(posedge clk) begin
        if (!rst_n) rev_cnt_q <= '0;
        else        rev_cnt_q <= rev_cnt_d;
    end
`endif

    assign sel          = sel_q;
    assign switch_pulse = pulse_q;
    assign both_fail    = (state_q == S_FAIL);
    assign holdoff      = hold_q;
    assign switch_cnt   = cnt_q;

endmodule
